// File: rtl/rho_rotate_engine.sv
// Rho-step lane rotator: streams NUM_LANES lanes through a 1-cycle-latency memory and writes each back rotated.
// Optional ROTATE_INVERSE_EN adds an 'inv' port selecting right (decode) rotation.
module rho_rotate_engine #(
  parameter int LANE_W    = 64,
  parameter int NUM_LANES = 25,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef ROTATE_INVERSE_EN
  input  logic              inv,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [LANE_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [LANE_W-1:0] mem_wr_data,
  output logic [1:0]        state_dbg
);

  localparam int SH_W = $clog2(LANE_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_LANE = ADDR_W'(NUM_LANES - 1);

  // Memory strobes carry no backpressure: mem_rd_en with mem_rd_addr requests a lane whose data
  // must appear on mem_rd_data exactly one cycle later; mem_wr_en qualifies mem_wr_addr/mem_wr_data.

  logic [1:0]        state;
  logic [ADDR_W-1:0] lane_cnt;
  logic [SH_W-1:0]   shamt;
  logic [LANE_W-1:0] rotated;
`ifdef ROTATE_INVERSE_EN
  logic              inv_q;
`endif

  function automatic logic [SH_W-1:0] rho_offset(input logic [ADDR_W-1:0] lane);
    int unsigned r;
    r = 0;
    case (int'(lane))
      0:  r = 0;   1:  r = 1;   2:  r = 62;  3:  r = 28;  4:  r = 27;
      5:  r = 36;  6:  r = 44;  7:  r = 6;   8:  r = 55;  9:  r = 20;
      10: r = 3;   11: r = 10;  12: r = 43;  13: r = 25;  14: r = 39;
      15: r = 41;  16: r = 45;  17: r = 15;  18: r = 21;  19: r = 8;
      20: r = 18;  21: r = 2;   22: r = 61;  23: r = 56;  24: r = 14;
      default: r = 0;
    endcase
    return SH_W'(r % LANE_W);
  endfunction

  // The lane being written is the one read last cycle, so its offset is keyed by mem_wr_addr.
  always_comb begin
    shamt   = rho_offset(mem_wr_addr);
    rotated = LANE_W'(({mem_rd_data, mem_rd_data} << shamt) >> LANE_W);
`ifdef ROTATE_INVERSE_EN
    if (inv_q) rotated = LANE_W'({mem_rd_data, mem_rd_data} >> shamt);
`endif
  end

  assign mem_wr_data = mem_wr_en ? rotated : '0;
  assign mem_rd_addr = lane_cnt;
  assign busy        = (state != ST_IDLE);
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      lane_cnt    <= '0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
`ifdef ROTATE_INVERSE_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      mem_wr_en   <= mem_rd_en;
      mem_wr_addr <= mem_rd_addr;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !done) begin
            state     <= ST_RUN;
            mem_rd_en <= 1'b1;
            lane_cnt  <= '0;
`ifdef ROTATE_INVERSE_EN
            inv_q     <= inv;
`endif
          end
        end
        ST_RUN: begin
          if (lane_cnt == LAST_LANE) begin
            state     <= ST_FLUSH;
            mem_rd_en <= 1'b0;
          end else begin
            lane_cnt <= lane_cnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          state    <= ST_IDLE;
          done     <= 1'b1;
          lane_cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rho_rotate_engine.sv
// Directed bench for rho_rotate_engine: a 64-bit/25-lane instance and a 32-bit/3-lane instance
// share one clock; each has its own behavioural one-cycle-latency lane memory.
module tb_rho_rotate_engine;

  localparam int N = 25;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-bit instance
  logic        start, busy, done, rd_en, wr_en;
  logic [4:0]  rd_addr, wr_addr;
  logic [63:0] rd_data, wr_data;
  logic [1:0]  state_dbg;
`ifdef ROTATE_INVERSE_EN
  logic        inv;
`endif

  // 32-bit instance
  logic        start2, busy2, done2, rd_en2, wr_en2;
  logic [4:0]  rd_addr2, wr_addr2;
  logic [31:0] rd_data2, wr_data2;
  logic [1:0]  state_dbg2;
`ifdef ROTATE_INVERSE_EN
  logic        inv2;
  initial inv2 = 1'b0;
`endif

  rho_rotate_engine #(.LANE_W(64), .NUM_LANES(N), .ADDR_W(5)) u_dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ROTATE_INVERSE_EN
    .inv(inv),
`endif
    .busy(busy), .done(done),
    .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data),
    .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data),
    .state_dbg(state_dbg)
  );

  rho_rotate_engine #(.LANE_W(32), .NUM_LANES(3), .ADDR_W(5)) u_dut32 (
    .clk(clk), .rst(rst), .start(start2),
`ifdef ROTATE_INVERSE_EN
    .inv(inv2),
`endif
    .busy(busy2), .done(done2),
    .mem_rd_en(rd_en2), .mem_rd_addr(rd_addr2), .mem_rd_data(rd_data2),
    .mem_wr_en(wr_en2), .mem_wr_addr(wr_addr2), .mem_wr_data(wr_data2),
    .state_dbg(state_dbg2)
  );

  logic [63:0] mem   [0:N-1];
  logic [31:0] mem32 [0:2];

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en2) rd_data2 <= mem32[rd_addr2];
    if (wr_en2) mem32[wr_addr2] <= wr_data2;
  end

  // scoreboard
  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int r_tab [0:24] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                       41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit-by-bit reference rotation of a 64-bit lane.
  function automatic logic [63:0] ref_rot(input logic [63:0] x, input int sh, input bit right);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      if (!right) y[(i + sh) % 64] = x[i];
      else        y[i] = x[(i + sh) % 64];
    end
    return y;
  endfunction

  task automatic load_exp(input bit right);
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(ref_rot(mem[k], r_tab[k] % 64, right));
  endtask

  // One full operation; start is high in cycle 0, optional extra start pulse in restart_cycle.
  task automatic run_op(input int restart_cycle, input string name);
    int wr_cnt;
    logic [63:0] e;
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge clk);
      start = (c == restart_cycle);
      check_val($sformatf("%s busy@%0d", name, c), {63'd0, busy}, {63'd0, (c >= 1 && c <= N + 1)});
      check_val($sformatf("%s done@%0d", name, c), {63'd0, done}, {63'd0, (c == N + 2)});
      check_val($sformatf("%s rd_en@%0d", name, c), {63'd0, rd_en}, {63'd0, (c >= 1 && c <= N)});
      check_val($sformatf("%s wr_en@%0d", name, c), {63'd0, wr_en}, {63'd0, (c >= 2 && c <= N + 1)});
      if (c >= 1 && c <= N)
        check_val($sformatf("%s rd_addr@%0d", name, c), {59'd0, rd_addr}, 64'(c - 1));
      if (wr_en) begin
        wr_cnt++;
        check_val($sformatf("%s wr_addr@%0d", name, c), {59'd0, wr_addr}, 64'(c - 2));
        if (exp_q.size() == 0) begin
          check_val($sformatf("%s extra_write@%0d", name, c), {63'd0, wr_en}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val($sformatf("%s wr_data@%0d", name, c), wr_data, e);
        end
      end
    end
    start = 1'b0;
    check_val({name, " write_count"}, 64'(wr_cnt), 64'(N));
  endtask

  logic [63:0] orig [0:N-1];
  bit seen;

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
`ifdef ROTATE_INVERSE_EN
    inv    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_val("rst busy", {63'd0, busy}, 64'd0);
    check_val("rst done", {63'd0, done}, 64'd0);
    check_val("rst rd_en", {63'd0, rd_en}, 64'd0);
    check_val("rst wr_en", {63'd0, wr_en}, 64'd0);
    check_val("rst rd_addr", {59'd0, rd_addr}, 64'd0);
    check_val("rst wr_addr", {59'd0, wr_addr}, 64'd0);
    check_val("rst wr_data", wr_data, 64'd0);
    rst = 1'b1;

    // Full 25-lane left pass with a second start in cycle 10 that must be ignored.
    for (int k = 0; k < N; k++) mem[k] = {$urandom, $urandom};
    mem[0] = 64'hDEAD_BEEF;
    mem[1] = 64'h1;
    mem[2] = 64'h1;
    load_exp(1'b0);
    run_op(10, "pass0");
    check_val("lane0 unchanged", mem[0], 64'hDEAD_BEEF);
    check_val("lane1 rot1", mem[1], 64'h2);
    check_val("lane2 rot62", mem[2], 64'h4000_0000_0000_0000);

    // 32-bit, 3-lane instance.
    mem32[0] = 32'h8000_0001;
    mem32[1] = 32'h1;
    mem32[2] = 32'h1;
    @(negedge clk);
    start2 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      check_val($sformatf("w32 busy@%0d", c), {63'd0, busy2}, {63'd0, (c >= 1 && c <= 4)});
      check_val($sformatf("w32 done@%0d", c), {63'd0, done2}, {63'd0, (c == 5)});
      if (c == 2) check_val("w32 lane0 data", {32'd0, wr_data2}, 64'h8000_0001);
      if (c == 3) check_val("w32 lane1 data", {32'd0, wr_data2}, 64'h2);
      if (c == 4) begin
        check_val("w32 lane2 addr", {59'd0, wr_addr2}, 64'd2);
        check_val("w32 lane2 data", {32'd0, wr_data2}, 64'h4000_0000);
      end
    end

    // Reset mid-operation in cycle 12.
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check_val("abort busy", {63'd0, busy}, 64'd0);
    check_val("abort done", {63'd0, done}, 64'd0);
    check_val("abort rd_en", {63'd0, rd_en}, 64'd0);
    check_val("abort wr_en", {63'd0, wr_en}, 64'd0);
    check_val("abort rd_addr", {59'd0, rd_addr}, 64'd0);
    check_val("abort wr_addr", {59'd0, wr_addr}, 64'd0);
    check_val("abort wr_data", wr_data, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (wr_en || rd_en || busy) seen = 1'b1;
    end
    check_val("abort quiet", {63'd0, seen}, 64'd0);
    load_exp(1'b0);
    run_op(-1, "post_rst");

`ifdef ROTATE_INVERSE_EN
    // Left pass then inverse pass must restore the original state.
    for (int k = 0; k < N; k++) mem[k] = {$urandom, $urandom};
    mem[1] = 64'h1;
    for (int k = 0; k < N; k++) orig[k] = mem[k];
    inv = 1'b0;
    load_exp(1'b0);
    run_op(-1, "fwd");
    check_val("fwd lane1", mem[1], 64'h2);
    inv = 1'b1;
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(orig[k]);
    run_op(-1, "inv");
    inv = 1'b0;
    for (int k = 0; k < N; k++) check_val($sformatf("restore lane%0d", k), mem[k], orig[k]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
